// File: rtl/retry_pkg.sv
// Shared types for the retry scheduler: QoS index width helper, FSM state
// encoding and the retransmit word layout.
package retry_pkg;

  function automatic int unsigned qos_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned RETRY_QOS_CLASS_NUM = 4;
  localparam int unsigned RETRY_SRC_NODE_W    = 2;
  localparam int unsigned RETRY_PAYLD_BW      = 8;
  localparam int unsigned RETRY_QW            = qos_w(RETRY_QOS_CLASS_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_GAP
  } state_e;

  typedef struct packed {
    logic [RETRY_QW-1:0]         qos;
    logic [RETRY_PAYLD_BW-1:0]   payload;
    logic [RETRY_SRC_NODE_W-1:0] des_id;
  } tx_word_t;

endpackage

// File: rtl/retry_scheduler_wrr_arbiter.sv
// Weighted round-robin arbiter: per-class credits, rotating pointer and
// whole-set credit reload when pending work exists but no credit remains.
module wrr_arbiter
  import retry_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned PW      = qos_w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          pending_nz_i,
  input  logic [N*WEIGHT_W-1:0] cfg_weight_i,
  input  logic                  take_i,
  output logic [N-1:0]          grant_o,
  output logic                  grant_valid_o
);

  logic [N-1:0][WEIGHT_W-1:0] credit_q, credit_d, eff, wload;
  logic                       fresh_q, fresh_d;
  logic [PW-1:0]              ptr_q, ptr_d, gidx;
  logic [N-1:0]               elig;
  logic                       found, reload;
  int unsigned                idx;

  // fresh_q stands in for "credits == weights" after reset, so the reset
  // value stays constant and the weights are picked up on first use.
  always_comb begin
    wload = '0;
    eff   = '0;
    elig  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      wload[i] = (cfg_weight_i[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                 WEIGHT_W'(1) : cfg_weight_i[i*WEIGHT_W +: WEIGHT_W];
      eff[i]   = fresh_q ? wload[i] : credit_q[i];
      elig[i]  = pending_nz_i[i] && (eff[i] != '0);
    end
  end

  always_comb begin
    grant_o = '0;
    gidx    = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (int'(ptr_q) + off) % N;
      if (!found && elig[PW'(idx)]) begin
        found             = 1'b1;
        gidx              = PW'(idx);
        grant_o[PW'(idx)] = 1'b1;
      end
    end
    grant_valid_o = found;
    reload        = (|pending_nz_i) && !(|elig);
  end

  always_comb begin
    credit_d = credit_q;
    fresh_d  = fresh_q;
    ptr_d    = ptr_q;
    if (reload) begin
      credit_d = wload;
      fresh_d  = 1'b0;
    end else if (take_i && found) begin
      credit_d       = eff;
      credit_d[gidx] = eff[gidx] - 1'b1;
      fresh_d        = 1'b0;
      ptr_d          = gidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
      fresh_q  <= 1'b1;
      ptr_q    <= PW'(N - 1);
    end else begin
      credit_q <= credit_d;
      fresh_q  <= fresh_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: rtl/retry_scheduler.sv
// Retry scheduler: mirrors buffer occupancy per QoS class, reads one entry at
// a time under WRR, and presents it on a valid/ready port with a minimum gap.
module retry_scheduler
  import retry_pkg::*;
#(
  parameter int unsigned ENTRY_NUM     = 32,
  parameter int unsigned QOS_CLASS_NUM = RETRY_QOS_CLASS_NUM,
  parameter int unsigned SRC_NODE_W    = RETRY_SRC_NODE_W,
  parameter int unsigned PAYLD_BW      = RETRY_PAYLD_BW,
  parameter int unsigned WEIGHT_W      = 4,
  parameter int unsigned GAP_W         = 4,
  localparam int unsigned QW           = qos_w(QOS_CLASS_NUM),
  localparam int unsigned CW           = $clog2(ENTRY_NUM + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              buf_wr_en,
  input  logic [QW-1:0]                     buf_wr_qos,
  output logic [QOS_CLASS_NUM-1:0]          rd_en,
  input  logic [QW-1:0]                     buf_qos,
  input  logic [PAYLD_BW-1:0]               buf_payload,
  input  logic [SRC_NODE_W-1:0]             buf_des_id,
  input  logic [QOS_CLASS_NUM*WEIGHT_W-1:0] cfg_weight,
  input  logic [GAP_W-1:0]                  cfg_gap,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic [QW-1:0]                     tx_qos,
  output logic [PAYLD_BW-1:0]               tx_payload,
  output logic [SRC_NODE_W-1:0]             tx_des_id,
  output logic [QOS_CLASS_NUM*CW-1:0]       pending_cnt,
  output logic                              overflow
);

  logic [QOS_CLASS_NUM-1:0][CW-1:0] cnt_q, cnt_d;
  logic                             ovf_q, ovf_d;
  logic [QOS_CLASS_NUM-1:0]         pending_nz, grant, sel_q, sel_d;
  logic                             grant_valid, take;
  state_e                           state_q, state_d;
  logic [GAP_W-1:0]                 gap_q, gap_d;
  tx_word_t                         word_q, word_d;

  // A write and a read on the same class cancel; a full class drops the write.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < QOS_CLASS_NUM; i++) begin
      if (buf_wr_en && (buf_wr_qos == QW'(i)) && !rd_en[i]) begin
        if (cnt_q[i] == CW'(ENTRY_NUM)) ovf_d = 1'b1;
        else                            cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rd_en[i] && !(buf_wr_en && (buf_wr_qos == QW'(i))) &&
                   (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < QOS_CLASS_NUM; i++) pending_nz[i] = (cnt_q[i] != '0);
  end

  wrr_arbiter #(
    .N        (QOS_CLASS_NUM),
    .WEIGHT_W (WEIGHT_W)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .pending_nz_i  (pending_nz),
    .cfg_weight_i  (cfg_weight),
    .take_i        (take),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    sel_d   = sel_q;
    word_d  = word_q;
    take    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid && (gap_q == '0)) begin
          take    = 1'b1;
          sel_d   = grant;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        word_d  = '{qos: buf_qos, payload: buf_payload, des_id: buf_des_id};
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (cfg_gap == '0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = cfg_gap;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_d = (gap_q == '0) ? '0 : gap_q - 1'b1;
        if (gap_q <= GAP_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      gap_q   <= '0;
      sel_q   <= '0;
      word_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
    end
  end

  assign rd_en       = (state_q == S_ISSUE) ? sel_q : '0;
  assign tx_valid    = (state_q == S_SEND);
  assign tx_qos      = word_q.qos;
  assign tx_payload  = word_q.payload;
  assign tx_des_id   = word_q.des_id;
  assign pending_cnt = cnt_q;
  assign overflow    = ovf_q;

endmodule
